dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-port data memory. It lets the core load/store path (requester 0) and a debug/DMA port (requester 1) share the memory. It latches one request at a time, drives the memory's address, data, write, read and mask inputs for exactly one access cycle, and returns a registered response. It sits between the pipeline's MEM stage, the debug port and the data memory instance.

---
 rtl/dmem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter and access sequencer in front of the single-port data
// memory. Requester 0 is the core load/store path and requester 1 is the
// debug/DMA port. One request is latched at a time. The memory port is
// driven for exactly one ACCESS cycle, and a registered response follows
// in the RESP cycle. A new request can be accepted from RESP, so sustained
// throughput is one access every two cycles.
//
// Optional feature macro: DMEM_ARB_RR_EN
//   defined   -> round-robin tie-break; the requester that did not own the
//                previous access wins a tie
//   undefined -> fixed priority; requester 0 always wins a tie
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rN_req                access request; held stable until rN_gnt
//   rN_we                 1 = store, 0 = load
//   rN_addr  [AW-1:0]     byte address
//   rN_wdata [DW-1:0]     store data
//   rN_mask  [2:0]        funct3 size code (000,001,010,100,101 legal)
//   rN_gnt                one-cycle pulse, request accepted (ACCESS cycle)
//   rN_rvalid             one-cycle completion pulse (RESP cycle)
//   rN_rdata [DW-1:0]     load data while rN_rvalid, otherwise 0
//   rN_err                illegal size code / direction, valid with rvalid
//   mem_addr, mem_wr_data, mem_mask, mem_wr, mem_rd
//                         memory port, all zero outside ACCESS
//   mem_rdata [DW-1:0]    combinational read data from the memory
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [2:0]    r0_mask,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_err,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    input  logic [2:0]    r1_mask,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_err,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    output logic [2:0]    mem_mask,
    output logic          mem_wr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;

    logic          owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [2:0]    mask_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;

    logic          any_req;
    logic          arb_en;
    logic          pick_r1;
    logic          illegal;

    assign any_req = r0_req | r1_req;

    // Arbitration happens whenever the sequencer can accept a new access,
    // which is from IDLE and also from RESP for back-to-back operation.
    assign arb_en  = any_req && ((state_q == IDLE) || (state_q == RESP));

`ifdef DMEM_ARB_RR_EN
    // rr_ptr_q = 1 gives requester 1 priority on the next tie. It is set to
    // the requester that did not win, at every arbitration.
    logic rr_ptr_q;

    assign pick_r1 = r1_req & (~r0_req | rr_ptr_q);

    // Round-robin priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else if (arb_en) begin
            rr_ptr_q <= ~pick_r1;
        end
    end
`else
    assign pick_r1 = r1_req & ~r0_req;
`endif

    // Sub-word sizes 100/101 are unsigned loads only. 011, 110 and 111 are
    // never legal.
    assign illegal = (mask_q == 3'b011) || (mask_q[2:1] == 2'b11) ||
                     (mask_q[2] && we_q);

    // State register. Reset aborts any in-flight access immediately because
    // every memory-side output is decoded from this register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. ACCESS and RESP last exactly one cycle each.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = any_req ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch: the winner's fields are captured at arbitration so
    // the requester only needs to hold them until it sees gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else if (arb_en) begin
            owner_q <= pick_r1;
            we_q    <= pick_r1 ? r1_we    : r0_we;
            addr_q  <= pick_r1 ? r1_addr  : r0_addr;
            wdata_q <= pick_r1 ? r1_wdata : r0_wdata;
            mask_q  <= pick_r1 ? r1_mask  : r0_mask;
        end
    end

    // Response register, loaded at the end of ACCESS. Only a legal load
    // keeps memory data; stores and illegal accesses return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == ACCESS) begin
            rdata_q <= (!we_q && !illegal) ? mem_rdata : '0;
            err_q   <= illegal;
        end
    end

    // Output decode from state and owner. There is no path from req to any
    // output here.
    always_comb begin
        r0_gnt      = 1'b0;
        r1_gnt      = 1'b0;
        r0_rvalid   = 1'b0;
        r1_rvalid   = 1'b0;
        r0_rdata    = '0;
        r1_rdata    = '0;
        r0_err      = 1'b0;
        r1_err      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_mask    = '0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;

        if (state_q == ACCESS) begin
            r0_gnt      = ~owner_q;
            r1_gnt      = owner_q;
            mem_addr    = addr_q;
            mem_wr_data = wdata_q;
            mem_mask    = mask_q;
            mem_wr      = we_q & ~illegal;
            mem_rd      = ~we_q & ~illegal;
        end

        if (state_q == RESP) begin
            if (owner_q) begin
                r1_rvalid = 1'b1;
                r1_rdata  = rdata_q;
                r1_err    = err_q;
            end else begin
                r0_rvalid = 1'b1;
                r0_rdata  = rdata_q;
                r0_err    = err_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a small behavioural data memory.
// The memory writes on the negedge and returns sign- or zero-extended lanes
// combinationally, selected by mem_mask and mem_addr[1:0].
// Expectations for the tie test follow DMEM_ARB_RR_EN if it is defined.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [31:0] r0_addr = '0, r0_wdata = '0;
    logic [2:0]  r0_mask = '0;
    logic        r0_gnt, r0_rvalid, r0_err;
    logic [31:0] r0_rdata;

    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [31:0] r1_addr = '0, r1_wdata = '0;
    logic [2:0]  r1_mask = '0;
    logic        r1_gnt, r1_rvalid, r1_err;
    logic [31:0] r1_rdata;

    logic [31:0] mem_addr, mem_wr_data, mem_rdata;
    logic [2:0]  mem_mask;
    logic        mem_wr, mem_rd;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_mask(r0_mask), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_mask(r1_mask), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_mask(mem_mask),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: 64 words, negedge write, combinational read.
    logic [31:0] mem_array [0:63];

    initial begin
        for (int i = 0; i < 64; i++) mem_array[i] = '0;
    end

    always @(negedge clk) begin
        if (mem_wr) begin
            case (mem_mask)
                3'b000:  mem_array[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wr_data[7:0];
                3'b001:  mem_array[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wr_data[15:0];
                default: mem_array[mem_addr[7:2]] <= mem_wr_data;
            endcase
        end
    end

    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_word   = mem_array[mem_addr[7:2]];
        rd_byte   = rd_word[{mem_addr[1:0], 3'b000} +: 8];
        rd_half   = rd_word[{mem_addr[1], 4'b0000} +: 16];
        mem_rdata = rd_word;
        case (mem_mask)
            3'b000:  mem_rdata = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  mem_rdata = {24'h0, rd_byte};
            3'b001:  mem_rdata = {{16{rd_half[15]}}, rd_half};
            3'b101:  mem_rdata = {16'h0, rd_half};
            default: mem_rdata = rd_word;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".ctrl"},
                    {21'h0, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err,
                     mem_wr, mem_rd, mem_mask}, 32'h0);
        checkOutput({tag, ".rdata"}, r0_rdata | r1_rdata, 32'h0);
        checkOutput({tag, ".mem_addr"}, mem_addr, 32'h0);
        checkOutput({tag, ".mem_wr_data"}, mem_wr_data, 32'h0);
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] mask);
        if (port == 0) begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_mask = mask;
        end else begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_mask = mask;
        end
    endtask

    // Issues one request and follows it to rvalid with a 10-cycle budget.
    // Cycle 1 is the first posedge after the request is presented.
    task automatic runAccess(input int port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] mask,
                             output logic [31:0] rdata, output logic err,
                             output int gntCycle, output int rvCycle,
                             output logic sawWr, output logic sawRd);
        gntCycle = -1; rvCycle = -1; rdata = '0; err = 1'b0; sawWr = 1'b0; sawRd = 1'b0;
        applyStimulus(port, 1'b1, we, addr, wdata, mask);
        for (int cyc = 1; cyc <= 10 && rvCycle < 0; cyc++) begin
            @(posedge clk); #1;
            if (mem_wr) sawWr = 1'b1;
            if (mem_rd) sawRd = 1'b1;
            if ((port == 0) ? r0_gnt : r1_gnt) begin
                gntCycle = cyc;
                applyStimulus(port, 1'b0, we, addr, wdata, mask);
            end
            if ((port == 0) ? r0_rvalid : r1_rvalid) begin
                rvCycle = cyc;
                rdata   = (port == 0) ? r0_rdata : r1_rdata;
                err     = (port == 0) ? r0_err : r1_err;
            end
        end
        applyStimulus(port, 1'b0, we, addr, wdata, mask);
    endtask

    task automatic doCheckedAccess(input string tag, input int port, input logic we,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [2:0] mask, input logic [31:0] expRdata,
                                   input logic expErr, input logic expWr, input logic expRd);
        logic [31:0] rdata;
        logic        err, sawWr, sawRd;
        int          gntCycle, rvCycle;
        runAccess(port, we, addr, wdata, mask, rdata, err, gntCycle, rvCycle, sawWr, sawRd);
        checkOutput({tag, ".gnt_cycle"}, gntCycle, 32'd1);
        checkOutput({tag, ".rvalid_cycle"}, rvCycle, 32'd2);
        checkOutput({tag, ".rdata"}, rdata, expRdata);
        checkOutput({tag, ".err"}, {31'h0, err}, {31'h0, expErr});
        checkOutput({tag, ".mem_wr"}, {31'h0, sawWr}, {31'h0, expWr});
        checkOutput({tag, ".mem_rd"}, {31'h0, sawRd}, {31'h0, expRd});
    endtask

    initial begin
        int   gntOwner [4];
        int   gntCyc [4];
        int   nGnt;
        int   r1Count;
        int   extraGnt;
        logic sawRv;

        // ---- reset state, with a request pending to show gnt stays low ----
        r0_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        r0_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkAllZero("idle_after_reset");

        // ---- both requesters held for four accesses ----
        for (int i = 0; i < 4; i++) begin
            gntOwner[i] = -1;
            gntCyc[i]   = -1;
        end
        nGnt = 0; r1Count = 0; extraGnt = 0;
        applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
        applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h0, 3'b010);
        for (int cyc = 1; cyc <= 12 && nGnt < 4; cyc++) begin
            @(posedge clk); #1;
            if (r1_gnt) r1Count++;
            if (r0_gnt && nGnt < 4) begin gntOwner[nGnt] = 0; gntCyc[nGnt] = cyc; nGnt++; end
            else if (r1_gnt && nGnt < 4) begin gntOwner[nGnt] = 1; gntCyc[nGnt] = cyc; nGnt++; end
        end
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        applyStimulus(1, 1'b0, 1'b0, 32'h4, 32'h0, 3'b010);
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(posedge clk); #1;
            if (r0_gnt || r1_gnt) extraGnt++;
        end
        checkOutput("tie.grant_count", nGnt, 32'd4);
        checkOutput("tie.first_gnt_cycle", gntCyc[0], 32'd1);
        for (int i = 1; i < 4; i++)
            checkOutput($sformatf("tie.gnt_spacing%0d", i), gntCyc[i] - gntCyc[i-1], 32'd2);
`ifdef DMEM_ARB_RR_EN
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("tie.owner%0d", i), gntOwner[i], i % 2);
        checkOutput("tie.r1_gnt_count", r1Count, 32'd2);
`else
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("tie.owner%0d", i), gntOwner[i], 32'd0);
        checkOutput("tie.r1_gnt_count", r1Count, 32'd0);
`endif
        checkOutput("tie.no_extra_gnt", extraGnt, 32'd0);

        // ---- store word then load it back on r0 ----
        doCheckedAccess("st_w_10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 1'b1, 1'b0);
        doCheckedAccess("ld_w_10", 0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);

        // ---- sub-word loads on r1 from word 0x8 = 0x80F01234 ----
        doCheckedAccess("st_w_08", 0, 1'b1, 32'h8, 32'h80F01234, 3'b010, 32'h0, 1'b0, 1'b1, 1'b0);
        doCheckedAccess("lb_0b", 1, 1'b0, 32'hB, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 1'b0, 1'b1);
        doCheckedAccess("lbu_0b", 1, 1'b0, 32'hB, 32'h0, 3'b100, 32'h00000080, 1'b0, 1'b0, 1'b1);
        doCheckedAccess("lh_0a", 1, 1'b0, 32'hA, 32'h0, 3'b001, 32'hFFFF80F0, 1'b0, 1'b0, 1'b1);
        doCheckedAccess("lhu_0a", 1, 1'b0, 32'hA, 32'h0, 3'b101, 32'h000080F0, 1'b0, 1'b0, 1'b1);
        doCheckedAccess("lb_08", 1, 1'b0, 32'h8, 32'h0, 3'b000, 32'h00000034, 1'b0, 1'b0, 1'b1);

        // ---- byte store through r1, word read back through r0 ----
        doCheckedAccess("sb_09", 1, 1'b1, 32'h9, 32'h000000AB, 3'b000, 32'h0, 1'b0, 1'b1, 1'b0);
        doCheckedAccess("ld_w_08", 0, 1'b0, 32'h8, 32'h0, 3'b010, 32'h80F0AB34, 1'b0, 1'b0, 1'b1);

        // ---- illegal accesses ----
        doCheckedAccess("ill_st_111", 0, 1'b1, 32'h20, 32'h12345678, 3'b111, 32'h0, 1'b1, 1'b0, 1'b0);
        doCheckedAccess("ld_w_20", 0, 1'b0, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0, 1'b0, 1'b1);
        doCheckedAccess("ill_ld_011", 0, 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 1'b0, 1'b0);
        doCheckedAccess("ill_st_100", 1, 1'b1, 32'h10, 32'h0, 3'b100, 32'h0, 1'b1, 1'b0, 1'b0);
        doCheckedAccess("ld_w_10_kept", 1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);

        // ---- reset in the middle of an ACCESS store, before the negedge ----
        applyStimulus(0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010);
        @(posedge clk); #1;
        checkOutput("abort.mem_wr_before", {31'h0, mem_wr}, 32'h1);
        checkOutput("abort.mem_addr_before", mem_addr, 32'h30);
        applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010);
        #1 rst_n = 1'b0;
        #1;
        checkAllZero("abort");
        sawRv = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge clk); #1;
            if (r0_rvalid || r1_rvalid) sawRv = 1'b1;
        end
        checkOutput("abort.no_rvalid", {31'h0, sawRv}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkAllZero("abort_idle");
        doCheckedAccess("ld_w_30", 0, 1'b0, 32'h30, 32'h0, 3'b010, 32'h0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
